corner_stream_out: RTL and testbench
====================================

// Module: corner_stream_out
// PURPOSE
//  Output side of the window pipeline: takes the per-pixel corner results produced from the 6x6 windows
//  and re-emits them as a full-frame raster stream with valid/ready handshake.
//  - Input has no backpressure: one result per window-valid cycle, only for window-centre rows.
//  - Re-inserts the zero border rows that the window cannot cover, and marks start-of-frame and end-of-line.
//  - Sits between the corner-response stage and the display/DMA sink.
// PARAMETERS
//  IMG_WIDTH   480  pixels per line
//  IMG_HEIGHT  360  lines per output frame
//  TOP_PAD     2    zero lines emitted before the first result line
//  BOT_PAD     3    zero lines emitted after the last result line (TOP_PAD+BOT_PAD = window size - 1)
//  FIFO_DEPTH  512  result FIFO entries, power of two, >= IMG_WIDTH
// PORTS
//  clk         in   1   single clock, all logic rising edge
//  reset       in   1   asynchronous, active-low reset
//  in_data     in   8   corner result for one pixel
//  in_valid    in   1   in_data valid this cycle
//  in_ready    out  1   FIFO can accept; informational only, producer does not stall
//  out_data    out  8   output pixel
//  out_valid   out  1   out_data valid; held stable until accepted
//  out_ready   in   1   sink accepts when out_valid & out_ready
//  out_sof     out  1   qualifies first pixel of frame (row 0, col 0)
//  out_eol     out  1   qualifies last pixel of each line (col IMG_WIDTH-1)
//  frame_done  out  1   one-cycle pulse after last pixel of frame accepted
//  overflow    out  1   sticky: a result was dropped because FIFO was full
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE; row, col and FIFO pointers = 0.
//    All outputs 0 except in_ready=1. Reset mid-frame discards FIFO contents and the partial frame.
//  - in_ready = !fifo_full (combinational).
//  - Write: in_valid & !full pushes. in_valid & full drops the data and sets overflow.
//    A push is rejected while full even if a pop happens in the same cycle.
//  - Output register: loaded when (!out_valid | out_ready) and the FSM has a pixel to emit.
//    out_data, out_sof and out_eol are registered together with out_valid.
//  - Latency: push at edge N -> out_valid no earlier than edge N+2 (FIFO read, then output reg).
//  - FSM states and transitions:
//    IDLE     -> PAD_TOP on the first accepted push. No output is produced in IDLE.
//    PAD_TOP  emits TOP_PAD*IMG_WIDTH pixels of 0x00, then -> STREAM.
//    STREAM   pops one FIFO entry per emitted pixel and stalls (out_valid=0) while the FIFO is empty.
//             Emits (IMG_HEIGHT-TOP_PAD-BOT_PAD)*IMG_WIDTH pixels, then -> PAD_BOT.
//    PAD_BOT  emits BOT_PAD*IMG_WIDTH zeros. On the last acceptance: frame_done=1 for one cycle, -> IDLE.
//  - Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 advance only on out_valid & out_ready.
//    col wraps to 0 and increments row; row wraps to 0 at the frame end.
//  - Pushes arriving during PAD_TOP/PAD_BOT/IDLE are stored; they belong to the current or next frame.
//  - If TOP_PAD=0, IDLE goes directly to STREAM. If BOT_PAD=0, the frame_done pulse comes at the end of STREAM.
//  - FIFO occupancy counter width = $clog2(FIFO_DEPTH)+1; no wrap. Pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
//  - Shared package hcd_pkg: IMG_WIDTH, IMG_HEIGHT, WIN_SIZE (=6) and the FSM state encoding
//    IDLE/PAD_TOP/STREAM/PAD_BOT (2-bit).
//    These are shared with the line-buffer/window control block.
//  - One sub-module: result_fifo (synchronous FIFO, same clk/reset, push/pop/full/empty/dout).
//    Remaining logic (FSM, counters, output reg) stays in this module.
// TESTING
//  1. Reset with no input, 100 cycles -> out_valid=0, in_ready=1, overflow=0.
//  2. out_ready=1; push 355*480 ramp values (data=col%256) -> 960 zeros with out_sof on the first.
//     Then the ramp in order, then 1440 zeros. out_eol on every col 479; frame_done once after pixel 172799.
//  3. out_ready toggled randomly 50% -> identical pixel order and count.
//     out_data stays stable while out_valid & !out_ready.
//  4. out_ready=0, push 513 values -> in_ready=0 after 512, overflow=1 and sticky.
//     Releasing out_ready drains exactly 512 values.
//  5. Assert reset mid-STREAM (row 100) -> all outputs at reset values immediately.
//     The next frame starts with out_sof and a zero top pad.
//  6. Two frames back-to-back with pushes arriving during PAD_BOT -> second frame intact.
//     frame_done is pulsed twice.

Source files
------------

// File: rtl/hcd_pkg.sv
// Constants and FSM encoding shared by the window-pipeline blocks
// (line-buffer/window control and the corner output stage).
package hcd_pkg;

  localparam int IMG_WIDTH  = 480;
  localparam int IMG_HEIGHT = 360;
  localparam int WIN_SIZE   = 6;
  localparam int TOP_PAD    = 2;
  localparam int BOT_PAD    = WIN_SIZE - 1 - TOP_PAD;
  localparam int FIFO_DEPTH = 512;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAD_TOP = 2'd1;
  localparam logic [1:0] ST_STREAM  = 2'd2;
  localparam logic [1:0] ST_PAD_BOT = 2'd3;

endpackage

// File: rtl/corner_stream_out_result_fifo.sv
// Synchronous show-ahead FIFO: RAM array plus one prefetch register, so o_dout
// is valid whenever o_empty is low and a pop simply consumes it.
module result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              r_doutValid;
  logic [DATA_W-1:0] r_dout;

  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic [CW-1:0]     w_memCount;

  // r_count covers both the RAM and the prefetch register, so full means DEPTH entries total.
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = ~r_doutValid;
  assign o_dout     = r_dout;
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & r_doutValid;
  assign w_memCount = r_count - {{AW{1'b0}}, r_doutValid};
  assign w_load     = (~r_doutValid | w_pop) & (w_memCount != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_din;
    if (w_load) r_dout <= r_mem[r_rdPtr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_doutValid <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_load) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load)     r_doutValid <= 1'b1;
      else if (w_pop) r_doutValid <= 1'b0;
    end
  end

endmodule

// File: rtl/corner_stream_out.sv
// Re-emits per-pixel corner results as a full raster frame with zero border rows,
// start-of-frame / end-of-line flags and a valid/ready output handshake.
module corner_stream_out #(
  parameter int IMG_WIDTH  = hcd_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = hcd_pkg::IMG_HEIGHT,
  parameter int TOP_PAD    = hcd_pkg::TOP_PAD,
  parameter int BOT_PAD    = hcd_pkg::BOT_PAD,
  parameter int FIFO_DEPTH = hcd_pkg::FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eol,
  output logic       frame_done,
  output logic       overflow
);

  import hcd_pkg::*;

  localparam int COL_W      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int STREAM_END = IMG_HEIGHT - BOT_PAD;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  logic [1:0]       r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_outValid;
  logic [7:0]       r_outData;
  logic             r_outSof;
  logic             r_outEol;
  logic             r_frameDone;
  logic             r_overflow;

  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic [7:0]       w_fifoDout;
  logic             w_push;
  logic             w_pop;
  logic             w_accept;
  logic             w_lastCol;
  logic             w_lastRow;
  logic             w_frameEnd;
  logic [COL_W-1:0] w_nextCol;
  logic [ROW_W-1:0] w_nextRow;
  logic [1:0]       w_region;
  logic             w_stream;
  logic             w_load;
  logic [1:0]       w_stateNext;

  result_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_din   (in_data),
    .i_pop   (w_pop),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_dout  (w_fifoDout)
  );

  assign w_push = in_valid & ~w_fifoFull;

  // Row/col point at the pixel held in the output register, or at the next one
  // to emit when the register is empty; w_next* is therefore the pixel to load now.
  always_comb begin
    w_accept   = r_outValid & out_ready;
    w_lastCol  = (r_col == LAST_COL);
    w_lastRow  = (r_row == LAST_ROW);
    w_frameEnd = w_accept & w_lastCol & w_lastRow;
    w_nextCol  = r_col;
    w_nextRow  = r_row;
    if (w_accept) begin
      if (w_lastCol) begin
        w_nextCol = '0;
        w_nextRow = w_lastRow ? '0 : r_row + 1'b1;
      end else begin
        w_nextCol = r_col + 1'b1;
      end
    end

    if (int'(w_nextRow) < TOP_PAD)          w_region = ST_PAD_TOP;
    else if (int'(w_nextRow) >= STREAM_END) w_region = ST_PAD_BOT;
    else                                    w_region = ST_STREAM;
    w_stream = (w_region == ST_STREAM);

    w_load = (~r_outValid | out_ready) & (r_state != ST_IDLE) & ~w_frameEnd
           & (~w_stream | ~w_fifoEmpty);
    w_pop  = w_load & w_stream;

    // Results stored during the previous frame's bottom pad also start the next frame.
    w_stateNext = r_state;
    if (r_state == ST_IDLE) begin
      if (w_push | ~w_fifoEmpty) w_stateNext = (TOP_PAD > 0) ? ST_PAD_TOP : ST_STREAM;
    end else begin
      w_stateNext = w_frameEnd ? ST_IDLE : w_region;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outSof    <= 1'b0;
      r_outEol    <= 1'b0;
      r_frameDone <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_col       <= w_nextCol;
      r_row       <= w_nextRow;
      r_frameDone <= w_frameEnd;
      r_overflow  <= r_overflow | (in_valid & w_fifoFull);
      if (w_load) begin
        r_outValid <= 1'b1;
        r_outData  <= w_stream ? w_fifoDout : 8'h00;
        r_outSof   <= (w_nextRow == '0) && (w_nextCol == '0);
        r_outEol   <= (w_nextCol == LAST_COL);
      end else if (w_accept) begin
        r_outValid <= 1'b0;
        r_outData  <= '0;
        r_outSof   <= 1'b0;
        r_outEol   <= 1'b0;
      end
    end
  end

  assign in_ready   = ~w_fifoFull;
  assign out_data   = r_outData;
  assign out_valid  = r_outValid;
  assign out_sof    = r_outSof;
  assign out_eol    = r_outEol;
  assign frame_done = r_frameDone;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_corner_stream_out.sv
// Randomized bench for corner_stream_out on a reduced frame; expected pixels come
// from the frame layout rule (pad rows of zeros around results in push order).
module tb_corner_stream_out;

  localparam int W      = 16;
  localparam int H      = 12;
  localparam int T      = 2;
  localparam int B      = 3;
  localparam int D      = 32;
  localparam int BUDGET = 5000;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;
  logic       frame_done;
  logic       overflow;

  corner_stream_out #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .TOP_PAD    (T),
    .BOT_PAD    (B),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         totalChecks = 0;
  int         badChecks   = 0;
  logic [7:0] modelQ[$];
  int         pixIdx;
  int         doneCount = 0;
  int         pushedTotal;
  int         consumedTotal;
  bit         doneDue;
  bit         lastAcc;
  bit         modelOverflow;
  bit         prevStall;
  logic [7:0] prevData;
  logic       prevSof;
  logic       prevEol;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    modelQ.delete();
    pixIdx        = 0;
    doneDue       = 1'b0;
    modelOverflow = 1'b0;
    prevStall     = 1'b0;
    pushedTotal   = 0;
    consumedTotal = 0;
  endtask

  task automatic doReset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    clearModel();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Frame layout model: pixel index -> row/col; pad rows are zero, others take results in order.
  always @(negedge clk) begin
    if (reset) begin
      logic [7:0] expData;
      if (prevStall) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, prevData);
        checkOutput("hold_sof", out_sof, prevSof);
        checkOutput("hold_eol", out_eol, prevEol);
      end
      if (frame_done || doneDue) checkOutput("frame_done", frame_done, doneDue);
      if (frame_done) doneCount++;
      lastAcc = 1'b0;
      if (out_valid && out_ready) begin
        int row, col;
        row = pixIdx / W;
        col = pixIdx % W;
        expData = 8'h00;
        if (row >= T && row < H - B) begin
          if (modelQ.size() == 0) checkOutput("underrun", 1, 0);
          else begin
            expData = modelQ.pop_front();
            consumedTotal++;
          end
        end
        checkOutput("pixel", out_data, expData);
        checkOutput("sof", out_sof, pixIdx == 0);
        checkOutput("eol", out_eol, col == W - 1);
        if (pixIdx == W * H - 1) lastAcc = 1'b1;
        pixIdx = (pixIdx + 1) % (W * H);
      end
      doneDue = lastAcc;
      if (in_valid) begin
        checkOutput("overflow", overflow, modelOverflow);
        if (in_ready) modelQ.push_back(in_data);
        else modelOverflow = 1'b1;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevSof   = out_sof;
      prevEol   = out_eol;
    end
  end

  task automatic applyStimulus(input int nResults, input int frames, input int readyPct,
                               input int gapPct, input bit ramp, input int stopPix);
    int sent, cyc, startDone;
    bit hit;
    sent = 0; cyc = 0; hit = 1'b0; startDone = doneCount;
    while (!hit && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      if (stopPix > 0) hit = (pixIdx >= stopPix);
      else hit = ((doneCount - startDone) >= frames);
      if (!hit) begin
        out_ready = ($urandom_range(99) < readyPct);
        if (sent < nResults && (pushedTotal - consumedTotal) < D && $urandom_range(99) >= gapPct) begin
          in_valid = 1'b1;
          in_data  = ramp ? 8'(sent % W) : 8'($urandom);
          sent++;
          pushedTotal++;
        end else begin
          in_valid = 1'b0;
        end
        cyc++;
      end
    end
    in_valid = 1'b0;
    checkOutput("stim_budget", hit, 1);
    if (stopPix == 0) begin
      checkOutput("frame_count", doneCount - startDone, frames);
      checkOutput("results_left", modelQ.size(), 0);
    end
  endtask

  localparam int RES_PER_FRAME = (H - T - B) * W;

  initial begin
    int startConsumed;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    clearModel();
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_overflow", overflow, 0);

    // Idle after reset with nothing pushed.
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i % 25 == 0) begin
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_in_ready", in_ready, 1);
        checkOutput("idle_overflow", overflow, 0);
      end
    end

    // Ramp frame at full throughput, then random data with random backpressure.
    applyStimulus(RES_PER_FRAME, 1, 100, 0, 1'b1, 0);
    applyStimulus(RES_PER_FRAME, 1, 50, 20, 1'b0, 0);

    // Overflow: sink stalled, push one more than the FIFO holds.
    doReset();
    for (int i = 0; i <= D; i++) begin
      @(posedge clk);
      #1;
      checkOutput("fill_in_ready", in_ready, i < D);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("full_overflow", overflow, 1);
    checkOutput("full_in_ready", in_ready, 0);
    repeat (5) @(posedge clk);
    #1 checkOutput("overflow_sticky", overflow, 1);
    startConsumed = consumedTotal;
    out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("drain_count", consumedTotal - startConsumed, D);
    checkOutput("drain_left", modelQ.size(), 0);
    checkOutput("drain_stall", out_valid, 0);
    checkOutput("drain_overflow", overflow, 1);

    // Mid-stream asynchronous reset, then a clean frame.
    doReset();
    applyStimulus(RES_PER_FRAME, 1, 100, 10, 1'b0, 5 * W);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_data", out_data, 0);
    checkOutput("mid_rst_sof", out_sof, 0);
    checkOutput("mid_rst_eol", out_eol, 0);
    checkOutput("mid_rst_done", frame_done, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    checkOutput("mid_rst_ready", in_ready, 1);
    in_valid = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(RES_PER_FRAME, 1, 100, 0, 1'b1, 0);

    // Back-to-back frames; pushes overlap the first frame's bottom pad.
    applyStimulus(2 * RES_PER_FRAME, 2, 80, 30, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
